// File: rtl/fpga_robots_ps2_pkg.sv
// Shared PS/2 receive definitions: frame constants, default tuning and FSM state encoding.
// Pure declarations; no logic, no latency, no flow control.
package fpga_robots_ps2_pkg;

  localparam int PS2_DATA_BITS             = 8;
  localparam int PS2_FRAME_BITS            = 11;
  localparam int PS2_FILTER_LEN_DEFAULT    = 16;
  localparam int PS2_TIMEOUT_TICKS_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  // Odd parity over data plus parity bit: a good frame has an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// Pin-side and byte-side signals of the PS/2 receiver. master = the receiver,
// slave = the environment that drives the pins/tick and consumes bytes (no back-pressure).
interface ps2_receiver_if;
  import fpga_robots_ps2_pkg::*;

  logic                     sixus;
  logic                     ps2_clk_raw;
  logic                     ps2_dat_raw;
  logic [PS2_DATA_BITS-1:0] rx_dat;
  logic                     rx_stb;
  logic                     err_stb;
  logic                     err_par;
  logic                     err_frm;

  modport master (
    input  sixus, ps2_clk_raw, ps2_dat_raw,
    output rx_dat, rx_stb, err_stb, err_par, err_frm
  );

  modport slave (
    output sixus, ps2_clk_raw, ps2_dat_raw,
    input  rx_dat, rx_stb, err_stb, err_par, err_frm
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus level filter for one PS/2 pin; output follows the pin
// 2 + FILTER_LEN cycles after a stable change, pulses shorter than FILTER_LEN are dropped.
module ps2_line_filter
  import fpga_robots_ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q + CW'(1) == CW'(FILTER_LEN)) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: strobes each good byte (or a qualified error) 3 + FILTER_LEN
// cycles after the raw stop-bit clock fall; no back-pressure, the consumer must take every strobe.
module ps2_receiver
  import fpga_robots_ps2_pkg::*;
#(
  parameter int FILTER_LEN    = PS2_FILTER_LEN_DEFAULT,
  parameter int TIMEOUT_TICKS = PS2_TIMEOUT_TICKS_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  ps2_receiver_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW = $clog2(PS2_DATA_BITS);

  logic clk_filt, dat_filt;
  logic clk_prev_q;
  logic fall;
  logic timeout;

  ps2_state_e               state_q, state_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_q, par_d;
  logic [TW-1:0]            tick_q, tick_d;
  logic [PS2_DATA_BITS-1:0] rx_dat_q, rx_dat_d;
  logic                     rx_stb_q, rx_stb_d;
  logic                     err_stb_q, err_stb_d;
  logic                     err_par_q, err_par_d;
  logic                     err_frm_q, err_frm_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst    (rst),
    .line_i (bus.ps2_clk_raw),
    .line_o (clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk    (clk),
    .rst    (rst),
    .line_i (bus.ps2_dat_raw),
    .line_o (dat_filt)
  );

  assign fall    = clk_prev_q & ~clk_filt;
  assign timeout = (state_q != ST_IDLE) && bus.sixus && (tick_q + TW'(1) == TW'(TIMEOUT_TICKS));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tick_d    = tick_q;
    rx_dat_d  = rx_dat_q;
    rx_stb_d  = 1'b0;
    err_stb_d = 1'b0;
    err_par_d = err_par_q;
    err_frm_d = err_frm_q;

    if (state_q == ST_IDLE || fall) begin
      tick_d = '0;
    end else if (bus.sixus) begin
      tick_d = tick_q + TW'(1);
    end

    // A clock fall takes priority over a timeout landing in the same cycle.
    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_filt) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end else begin
            err_stb_d = 1'b1;
            err_frm_d = 1'b1;
            err_par_d = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_filt, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = dat_filt;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!dat_filt) begin
            err_stb_d = 1'b1;
            err_frm_d = 1'b1;
            err_par_d = 1'b0;
          end else if (!ps2_parity_ok(shift_q, par_q)) begin
            err_stb_d = 1'b1;
            err_frm_d = 1'b0;
            err_par_d = 1'b1;
          end else begin
            rx_dat_d = shift_q;
            rx_stb_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d   = ST_IDLE;
      err_stb_d = 1'b1;
      err_frm_d = 1'b1;
      err_par_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tick_q     <= '0;
      rx_dat_q   <= '0;
      rx_stb_q   <= 1'b0;
      err_stb_q  <= 1'b0;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
    end else begin
      clk_prev_q <= clk_filt;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tick_q     <= tick_d;
      rx_dat_q   <= rx_dat_d;
      rx_stb_q   <= rx_stb_d;
      err_stb_q  <= err_stb_d;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
    end
  end

  assign bus.rx_dat  = rx_dat_q;
  assign bus.rx_stb  = rx_stb_q;
  assign bus.err_stb = err_stb_q;
  assign bus.err_par = err_par_q;
  assign bus.err_frm = err_frm_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: frames driven on the raw pins, expected byte/error events queued by a
// frame-level model and matched by a monitor on every strobe (including exact strobe latency).
module tb_ps2_receiver;
  import fpga_robots_ps2_pkg::*;

  localparam int HALF = 40;
  localparam int LAT  = 19;

  typedef struct {
    bit         is_err;
    bit         par;
    bit         frm;
    logic [7:0] dat;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_receiver_if bus();

  ps2_receiver #(.FILTER_LEN(16), .TIMEOUT_TICKS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  exp_t       expq[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit good_parity(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Frame-level reference: stop error dominates, then odd-parity check, else a good byte.
  task automatic push_expect(input logic [7:0] d, input bit par, input bit stop);
    exp_t e;
    e.cyc = cyc + LAT;
    if (!stop) begin
      e.is_err = 1; e.frm = 1; e.par = 0; e.dat = last_good;
    end else if ((($countones(d) + par) % 2) != 1) begin
      e.is_err = 1; e.frm = 0; e.par = 1; e.dat = last_good;
    end else begin
      e.is_err = 0; e.frm = 0; e.par = 0; e.dat = d;
      last_good = d;
    end
    expq.push_back(e);
  endtask

  task automatic push_frm_err(input int at_cyc);
    exp_t e;
    e.is_err = 1; e.frm = 1; e.par = 0; e.dat = last_good; e.cyc = at_cyc;
    expq.push_back(e);
  endtask

  // Drives the first nbits of a frame; glitch adds a 5-cycle low pulse in each clock-high phase.
  task automatic send_frame(input logic [7:0] d, input bit par, input bit stop,
                            input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_dat_raw = bits[i];
      if (glitch) begin
        wait_cyc(10);
        bus.ps2_clk_raw = 1'b0;
        wait_cyc(5);
        bus.ps2_clk_raw = 1'b1;
        wait_cyc(HALF - 15);
      end else begin
        wait_cyc(HALF);
      end
      bus.ps2_clk_raw = 1'b0;
      if (i == 10) push_expect(d, par, stop);
      wait_cyc(HALF);
      bus.ps2_clk_raw = 1'b1;
    end
    bus.ps2_dat_raw = 1'b1;
    wait_cyc(HALF);
  endtask

  initial begin
    bus.sixus = 1'b0;
    forever begin
      repeat (9) @(posedge clk);
      #1 bus.sixus = 1'b1;
      @(posedge clk);
      #1 bus.sixus = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.rx_stb || bus.err_stb)) begin
      chk("strobe_exclusive", {31'd0, bus.rx_stb & bus.err_stb}, 32'd0);
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: rx_stb=%0b err_stb=%0b with nothing expected (cycle %0d)",
                 bus.rx_stb, bus.err_stb, cyc);
      end else begin
        e = expq.pop_front();
        chk("strobe_kind_err", {31'd0, bus.err_stb}, {31'd0, e.is_err});
        chk("rx_dat", {24'd0, bus.rx_dat}, {24'd0, e.dat});
        if (e.is_err) begin
          chk("err_par", {31'd0, bus.err_par}, {31'd0, e.par});
          chk("err_frm", {31'd0, bus.err_frm}, {31'd0, e.frm});
        end
        if (e.cyc > 0) chk("strobe_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached with %0d events pending", expq.size());
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         fault;
    bus.ps2_clk_raw = 1'b1;
    bus.ps2_dat_raw = 1'b1;
    rst = 1'b1;
    wait_cyc(3);
    chk("reset_rx_dat", {24'd0, bus.rx_dat}, 32'd0);
    chk("reset_rx_stb", {31'd0, bus.rx_stb}, 32'd0);
    chk("reset_err_stb", {31'd0, bus.err_stb}, 32'd0);
    chk("reset_err_par", {31'd0, bus.err_par}, 32'd0);
    chk("reset_err_frm", {31'd0, bus.err_frm}, 32'd0);
    rst = 1'b0;
    wait_cyc(5);

    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    send_frame(8'hF0, good_parity(8'hF0), 1'b1, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    send_frame(8'hA5, good_parity(8'hA5), 1'b0, 11, 1'b0);
    send_frame(8'h33, ~good_parity(8'h33), 1'b0, 11, 1'b0);

    // A clock fall while idle with data high is a bad start bit.
    bus.ps2_dat_raw = 1'b1;
    wait_cyc(HALF);
    bus.ps2_clk_raw = 1'b0;
    push_frm_err(cyc + LAT);
    wait_cyc(HALF);
    bus.ps2_clk_raw = 1'b1;
    wait_cyc(HALF);

    // Stalled clock after four data bits must time out.
    send_frame(8'h0F, 1'b1, 1'b1, 5, 1'b0);
    push_frm_err(0);
    wait_cyc(40 * 10);
    send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b0);

    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);

    // Mid-frame reset drops the partial frame and clears the held byte.
    send_frame(8'h77, 1'b1, 1'b1, 4, 1'b0);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    last_good = 8'h00;
    wait_cyc(1);
    chk("rst_mid_frame_rx_dat", {24'd0, bus.rx_dat}, 32'd0);
    wait_cyc(HALF);
    send_frame(8'h3C, good_parity(8'h3C), 1'b1, 11, 1'b0);

    for (int n = 0; n < 20; n++) begin
      d     = 8'($urandom);
      fault = $urandom_range(0, 3);
      send_frame(d, good_parity(d) ^ (fault == 2), (fault != 3), 11, 1'b0);
    end

    for (int w = 0; w < 200 && expq.size() > 0; w++) wait_cyc(1);
    chk("events_pending", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Receive-only PS/2 device-to-host deserializer. It samples the raw PS/2 clock and data pins, filters glitches, and assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop). Each valid byte is presented as a one-cycle strobe. It sits between the top-level `ps2a_clk`/`ps2a_dat` pins and the control block's `ps2_rx_dat`/`ps2_rx_stb` inputs, which are currently tied to zero. The top level keeps both pins high-impedance; this block never drives them.

## Interface

Parameters:
- `FILTER_LEN`, default 16: number of consecutive `clk` cycles a synchronized line must hold a new level before the filtered level changes (≈250 ns at 65 MHz).
- `TIMEOUT_TICKS`, default 32: number of `sixus` pulses without a filtered clock fall, mid-frame, before the frame is abandoned (≈192 µs).

Ports:
- `clk`, in, 1: system clock, ~65 MHz.
- `rst`, in, 1: reset, synchronous, active-high.
- `sixus`, in, 1: one-cycle pulse every ~6 µs, from the clock block.
- `ps2_clk_raw`, in, 1: asynchronous PS/2 clock pin.
- `ps2_dat_raw`, in, 1: asynchronous PS/2 data pin.
- `rx_dat`, out, 8: last good byte; holds its value between strobes.
- `rx_stb`, out, 1: one-cycle pulse when `rx_dat` is newly valid.
- `err_stb`, out, 1: one-cycle pulse when a frame is rejected.
- `err_par`, out, 1: qualifies `err_stb` as a parity error; holds until the next `err_stb`.
- `err_frm`, out, 1: qualifies `err_stb` as a start, stop or timeout error; holds until the next `err_stb`.

## Operation

- Line conditioning, per line:
  - Two-flop synchronizer.
  - Then a filter with a counter of width `$clog2(FILTER_LEN+1)`. The counter increments while the synchronized level differs from the filtered level and clears when they match.
  - When the counter reaches `FILTER_LEN`, the filtered level flips and the counter clears.
  - Both filtered levels reset to 1.
- Edge detect: `fall` is true for one cycle when the filtered clock goes 1→0.
- State machine, states IDLE, DATA, PARITY, STOP:
  - IDLE, on `fall`:
    - Filtered data = 0: go to DATA, clear bit count and shift register.
    - Filtered data = 1: pulse `err_stb` with `err_frm`=1, `err_par`=0, and stay in IDLE.
  - DATA, on `fall`: shift the data bit into bit 7, shifting right. After the 8th bit, go to PARITY.
  - PARITY, on `fall`: latch the parity bit, go to STOP.
  - STOP, on `fall`:
    - Data = 1 and (XOR of 8 data bits ^ parity bit) = 1: load `rx_dat`, pulse `rx_stb`.
    - Data = 0: `err_frm`.
    - Parity wrong with stop bit good: `err_par`.
    - If stop and parity are both bad, report `err_frm` only.
    - In all cases return to IDLE.
- Timeout:
  - A tick counter clears on every `fall` and in IDLE. It increments on `sixus` while not in IDLE.
  - Reaching `TIMEOUT_TICKS` means: pulse `err_stb` with `err_frm`=1, then go to IDLE.
  - If `fall` and the timeout occur in the same cycle, `fall` wins.
- `rx_stb` and `err_stb` are never asserted in the same cycle.

## Timing

- Reset values:
  - `rx_dat`=0x00; `rx_stb`, `err_stb`, `err_par`, `err_frm` = 0.
  - State = IDLE; synchronizers and filtered levels = 1; all counters = 0.
- A reset asserted mid-frame discards the partial frame. No strobe is produced.
- Latency: for stable raw inputs, `rx_stb` rises exactly 3 + `FILTER_LEN` `clk` cycles after the raw clock falls for the stop bit. That is 2 synchronizer cycles, `FILTER_LEN` filter cycles, and 1 registered output cycle.
- Data is sampled from the filtered data line on the cycle `fall` is detected. PS/2 holds data ≥5 µs around the clock fall, which exceeds the filter delay.
- Input rates: PS/2 clock at 10–16.7 kHz implies ≥ ~2000 `clk` cycles per bit. There is no back-pressure. The consumer must accept each `rx_stb`.

## Structure

- Shared package `fpga_robots_ps2_pkg` holds:
  - State encodings.
  - Constants `PS2_DATA_BITS`=8 and `PS2_FRAME_BITS`=11.
  - Default `FILTER_LEN` and `TIMEOUT_TICKS`.
- Sub-module `ps2_line_filter` (synchronizer plus filter), parameterized by `FILTER_LEN`. It is instantiated twice, once for clock and once for data.
- The state machine, shift register, and timeout logic live in `ps2_receiver`.

## Test plan

- Send 0x1C (parity 0, stop 1): one `rx_stb` with `rx_dat`=0x1C, no `err_stb`. Latency from the stop-bit fall is exactly 19 cycles with `FILTER_LEN`=16.
- Send 0xF0 then 0x1C back-to-back: two `rx_stb` pulses carrying 0xF0, then 0x1C.
- Send 0x1C with parity bit 1: `err_stb`, `err_par`=1, `err_frm`=0, no `rx_stb`. `rx_dat` keeps its previous value.
- Send a frame with stop bit 0: `err_stb` with `err_frm`=1.
- Stop the clocks after 4 data bits and wait 40 `sixus` ticks: `err_stb` with `err_frm`=1. A following 0x5A frame (parity 1) gives `rx_dat`=0x5A.
- Inject 5-cycle low glitches on the PS/2 clock during a 0x1C frame: they are ignored and 0x1C is received. Asserting `rst` for 1 cycle mid-frame gives no strobe, and the next frame is received correctly.
